// File: rtl/tx_pkg.sv
// Shared constants for the 802.11a transmit frame sequencer.
// Holds the rate table, state encoding and field sizes.
package tx_pkg;

    localparam int LEN_W        = 12;
    localparam int NSYM_W       = 11;
    localparam int SIGNAL_BITS  = 24;
    localparam int SERVICE_BITS = 16;
    localparam int TAIL_BITS    = 6;

    // Bit/quotient counter widths derived from the length field.
    localparam int CNT_W = LEN_W + 4;
    localparam int SUB_W = 8 + NSYM_W;

    localparam logic [1:0] ENC_R12 = 2'd0;
    localparam logic [1:0] ENC_R23 = 2'd1;
    localparam logic [1:0] ENC_R34 = 2'd2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR_S = 3'd1;
    localparam logic [2:0] S_SIG   = 3'd2;
    localparam logic [2:0] S_CLR_D = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_TAIL  = 3'd5;
    localparam logic [2:0] S_PAD   = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    // rbits holds R1..R4 with R1 in the MSB.
    typedef struct packed {
        logic [3:0] rbits;
        logic [7:0] ndbps;
        logic [1:0] enc;
    } rate_ent_t;

    function automatic rate_ent_t rate_lookup(input logic [2:0] sel);
        rate_ent_t e;
        case (sel)
            3'd0:    e = '{4'b1101, 8'd24,  ENC_R12};
            3'd1:    e = '{4'b1111, 8'd36,  ENC_R34};
            3'd2:    e = '{4'b0101, 8'd48,  ENC_R12};
            3'd3:    e = '{4'b0111, 8'd72,  ENC_R34};
            3'd4:    e = '{4'b1001, 8'd96,  ENC_R12};
            3'd5:    e = '{4'b1011, 8'd144, ENC_R34};
            3'd6:    e = '{4'b0001, 8'd192, ENC_R23};
            default: e = '{4'b0011, 8'd216, ENC_R34};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/tx_encoder_ctrl_sig.sv
// SIGNAL field builder: RATE, reserved, LENGTH, parity, tail.
// Bit i of sig_o is the i-th bit sent to the encoder.
module signal_field_gen
    import tx_pkg::*;
(
    input  logic [3:0]             rbits_i,
    input  logic [LEN_W-1:0]       length_i,
    output logic [SIGNAL_BITS-1:0] sig_o
);

    logic parity;

    // Even parity over RATE, reserved (0) and LENGTH.
    assign parity = ^{rbits_i, length_i};

    assign sig_o = {6'b000000, parity, length_i, 1'b0,
                    rbits_i[0], rbits_i[1], rbits_i[2], rbits_i[3]};

endmodule

// File: rtl/tx_encoder_ctrl.sv
// Frame sequencer feeding the convolutional encoder:
// SIGNAL, SERVICE+PSDU, tail and pad, with encoder clears.
module tx_encoder_ctrl
    import tx_pkg::*;
(
    input  logic              Clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        rate_sel,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [NSYM_W-1:0] n_sym,
    input  logic              in_valid,
    input  logic              in_bit,
    output logic              in_ready,
    input  logic              enc_ready,
    output logic              enc_en,
    output logic              enc_data,
    output logic [1:0]        enc_rate,
    output logic              enc_rst
);

    logic [2:0]        state_q, state_d;
    rate_ent_t         ent_q, ent_d, ent_in;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        bit_q, bit_d, bit_nx;
    logic [NSYM_W-1:0] nsym_q, nsym_d;
    logic [1:0]        erate_q, erate_d;
    logic              een_q, een_d;
    logic              edat_q, edat_d;
    logic              erst_q, erst_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  div_rem_q, div_rem_d;
    logic [NSYM_W-1:0] div_quo_q, div_quo_d;
    logic [3:0]        div_step_q, div_step_d;
    logic [3:0]        div_sidx;
    logic [SUB_W-1:0]  div_sub;
    logic              div_ge;
    logic              wrap;
    logic              issue, ibit;
    logic [SIGNAL_BITS-1:0] sig_vec;

    signal_field_gen u_sig (
        .rbits_i  (ent_q.rbits),
        .length_i (len_q),
        .sig_o    (sig_vec)
    );

    assign ent_in = rate_lookup(rate_sel);

    // Restoring divider step: n_sym = ceil(bits / N_DBPS), MSB first.
    assign div_sidx = div_step_q - 4'd1;
    assign div_sub  = SUB_W'(ent_q.ndbps) << div_sidx;
    assign div_ge   = SUB_W'(div_rem_q) >= div_sub;

    // Symbol bit counter wrap at N_DBPS-1.
    assign wrap   = bit_q == (ent_q.ndbps - 8'd1);
    assign bit_nx = wrap ? 8'd0 : bit_q + 8'd1;

    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done     = state_q == S_DONE;
    assign err      = err_q;
    assign n_sym    = nsym_q;
    assign in_ready = (state_q == S_DATA) && enc_ready;
    assign enc_en   = een_q;
    assign enc_data = edat_q;
    assign enc_rate = erate_q;
    assign enc_rst  = erst_q;

    // Next-state, bit issue and divider stepping.
    always_comb begin
        state_d    = state_q;
        ent_d      = ent_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        nsym_d     = nsym_q;
        erate_d    = erate_q;
        err_d      = 1'b0;
        div_rem_d  = div_rem_q;
        div_quo_d  = div_quo_q;
        div_step_d = div_step_q;
        issue      = 1'b0;
        ibit       = 1'b0;

        if (div_step_q != 4'd0) begin
            div_step_d = div_step_q - 4'd1;
            if (div_ge) begin
                div_rem_d = div_rem_q - div_sub[CNT_W-1:0];
            end
            div_quo_d = {div_quo_q[NSYM_W-2:0], div_ge};
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        err_d = 1'b1;
                    end else begin
                        ent_d      = ent_in;
                        len_d      = length;
                        erate_d    = ENC_R12;
                        div_rem_d  = CNT_W'(SERVICE_BITS + TAIL_BITS)
                                   + CNT_W'({length, 3'b000})
                                   + CNT_W'(ent_in.ndbps) - 1'b1;
                        div_quo_d  = '0;
                        div_step_d = 4'(NSYM_W);
                        state_d    = S_CLR_S;
                    end
                end
            end
            S_CLR_S: begin
                cnt_d   = '0;
                state_d = S_SIG;
            end
            S_SIG: begin
                if (enc_ready) begin
                    issue = 1'b1;
                    ibit  = sig_vec[cnt_q[4:0]];
                    if (cnt_q == CNT_W'(SIGNAL_BITS - 1)) begin
                        state_d = S_CLR_D;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_CLR_D: begin
                erate_d = ent_q.enc;
                nsym_d  = div_quo_q;
                bit_d   = '0;
                cnt_d   = CNT_W'(SERVICE_BITS) + CNT_W'({len_q, 3'b000});
                state_d = S_DATA;
            end
            S_DATA: begin
                if (enc_ready && in_valid) begin
                    issue = 1'b1;
                    ibit  = in_bit;
                    bit_d = bit_nx;
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = S_TAIL;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_TAIL: begin
                if (enc_ready) begin
                    issue = 1'b1;
                    bit_d = bit_nx;
                    if (cnt_q == CNT_W'(TAIL_BITS - 1)) begin
                        state_d = S_PAD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_PAD: begin
                if (bit_q == 8'd0) begin
                    state_d = S_DONE;
                end else if (enc_ready) begin
                    issue = 1'b1;
                    bit_d = bit_nx;
                    if (wrap) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                erate_d = ENC_R12;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        een_d  = issue;
        edat_d = ibit;
        erst_d = (state_q == S_CLR_S) || (state_q == S_CLR_D);
    end

    // State and output registers; reset aborts any frame.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ent_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            bit_q      <= '0;
            nsym_q     <= '0;
            erate_q    <= ENC_R12;
            een_q      <= 1'b0;
            edat_q     <= 1'b0;
            erst_q     <= 1'b0;
            err_q      <= 1'b0;
            div_rem_q  <= '0;
            div_quo_q  <= '0;
            div_step_q <= '0;
        end else begin
            state_q    <= state_d;
            ent_q      <= ent_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            nsym_q     <= nsym_d;
            erate_q    <= erate_d;
            een_q      <= een_d;
            edat_q     <= edat_d;
            erst_q     <= erst_d;
            err_q      <= err_d;
            div_rem_q  <= div_rem_d;
            div_quo_q  <= div_quo_d;
            div_step_q <= div_step_d;
        end
    end

endmodule

// File: doc/tx_encoder_ctrl.md
Name: tx_encoder_ctrl

Overview:
- Frame sequencer in front of the convolutional encoder (ports Clk, reset, en, rate, data_in, data_out) in the 802.11a transmit chain.
- For each frame it feeds the encoder, in order:
  - the SIGNAL field, built internally at rate 1/2;
  - SERVICE+PSDU bits pulled from the upstream scrambler;
  - 6 zero tail bits;
  - zero pad bits up to the next OFDM symbol boundary (N_DBPS).
- It also clears the encoder state before each field and selects the encoder rate per field.

Parameters:
- LEN_W, 12, width of the LENGTH field in bytes.
- NSYM_W, 11, width of the symbol counter; covers 6 Mbps at LENGTH=4095, which gives 1366 symbols.

Ports:
- Clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle frame request; accepted only in IDLE
- rate_sel  in  3  0..7 select 6,9,12,18,24,36,48,54 Mbps
- length  in  LEN_W  PSDU length in bytes, 1..4095
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last pad bit is issued
- err  out  1  one-cycle pulse when start arrives with length==0
- n_sym  out  NSYM_W  number of DATA symbols in the frame; valid while busy and at done
- in_valid  in  1  upstream bit valid
- in_bit  in  1  upstream SERVICE/PSDU bit, already scrambled
- in_ready  out  1  upstream bit accepted when in_valid&in_ready
- enc_ready  in  1  encoder can take a bit next cycle
- enc_en  out  1  drives encoder en
- enc_data  out  1  drives encoder data_in
- enc_rate  out  2  drives encoder rate: 0=1/2, 1=2/3, 2=3/4
- enc_rst  out  1  one-cycle synchronous clear of the encoder shift register

Behaviour:
- Reset: all outputs are 0, state=IDLE, counters=0. A reset mid-frame aborts immediately; no done pulse is produced.
- Rate table, rate_sel -> (RATE R1..R4, N_DBPS, enc_rate):
  - 0 -> (1101, 24, 0)
  - 1 -> (1111, 36, 2)
  - 2 -> (0101, 48, 0)
  - 3 -> (0111, 72, 2)
  - 4 -> (1001, 96, 0)
  - 5 -> (1011, 144, 2)
  - 6 -> (0001, 192, 1)
  - 7 -> (0011, 216, 2)
- Start handling:
  - In IDLE, start latches rate_sel and length.
  - If length==0: err pulses next cycle and the block stays in IDLE.
  - start while busy is ignored.
- States: IDLE -> CLR_S -> SIG -> CLR_D -> DATA -> TAIL -> PAD -> DONE -> IDLE.
- CLR_S / CLR_D:
  - Each lasts one cycle with enc_rst=1 and enc_en=0.
  - enc_rate is set to 0 in CLR_S and to the table value in CLR_D; it holds through the following field.
- SIG:
  - 24 bits, emitted in this order: R1..R4, reserved 0, LENGTH LSB first (12 bits), even parity over the preceding 17 bits, 6 zeros.
- DATA:
  - in_ready = enc_ready.
  - Each accepted bit appears on enc_data with enc_en=1 on the following cycle (registered, latency 1).
  - Exactly 16+8*length bits are accepted, then the block moves to TAIL; in_ready is 0 in every other state.
- TAIL: 6 zero bits.
- PAD:
  - Zero bits until the symbol bit counter wraps to 0.
  - If the counter is already 0 on entering PAD, no pad bits are issued and the block goes straight to DONE. This case is unreachable in 802.11a but must be handled.
- Issuing bits, in every bit-issuing state:
  - A bit is issued only in a cycle where enc_ready=1; when enc_ready=0, enc_en=0 the next cycle and no counter advances.
  - If in_valid=0 during DATA, enc_en=0 the next cycle.
- Counters:
  - Symbol bit counter: 0..N_DBPS-1. It runs over DATA+TAIL+PAD, wraps to 0, and increments n_sym on each wrap.
  - n_sym is precomputed at CLR_D as ceil((22+8*length)/N_DBPS) using iterative subtraction or a counter.
  - At done, the wrap count must equal n_sym; the bench checks this.
- DONE: done=1 for one cycle, busy drops in the same cycle, return to IDLE.

Decomposition:
- Shared package tx_pkg:
  - rate table entries (RATE bits, N_DBPS, encoder rate code);
  - state encoding;
  - SIGNAL_BITS=24, SERVICE_BITS=16, TAIL_BITS=6;
  - encoder rate codes.
- One natural sub-module: signal_field_gen. It takes the latched rate and length and produces the 24-bit SIGNAL vector with parity, combinationally.

Test Plan:
- rate_sel=0, length=1, enc_ready=1, in_valid=1:
  - SIG stream 1101 0 100000000000 0 000000;
  - enc_rate 0 throughout;
  - 24 DATA bits accepted, 6 tail, 18 pad;
  - n_sym=2, 48 DATA-phase enc_en cycles; done once.
- rate_sel=7, length=100:
  - enc_rate=2 in DATA;
  - 816 bits accepted, 6 tail, 42 pad;
  - n_sym=4, 864 DATA-phase enc_en cycles.
- rate_sel=6, length=1, enc_ready toggling 1,0 every cycle:
  - enc_en never asserted in the cycle after enc_ready=0;
  - bit order unchanged;
  - totals 24 + 192 enc_en cycles.
- length=0 start -> err pulse, busy stays 0. start while busy -> ignored, frame totals unchanged.
- reset asserted mid-DATA -> all outputs 0 at once, no done. A new start afterwards produces a complete correct frame beginning with an enc_rst pulse.
- rate_sel=0, length=4095 -> n_sym=1366, done after exactly 1366*24 DATA-phase bits.
